// File: rtl/pipeline_register_pkg.sv
// Shared constants and the stage record type for the pipeline register slice.
// The record holds one data word and the valid bit that qualifies it.
package pipeline_register_pkg;

    localparam int DEFAULT_PIPE_WIDTH = 8;

    // A packed typedef cannot take a module parameter, so this is the default-width record.
    // Parameterised modules declare the same {valid, data} layout at their own WIDTH.
    typedef struct packed {
        logic                          valid;
        logic [DEFAULT_PIPE_WIDTH-1:0] data;
    } pipe_stage_t;

    function automatic int stage_bits(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/pipeline_register_stage.sv
// One register slot holding a {valid, data} record.
// Priority on each rising edge, highest first: reset, flush, enable, hold.
module pipeline_stage
    import pipeline_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_PIPE_WIDTH
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t r_stage;

    always_ff @(posedge ck) begin
        if (!rst_n || i_flush) begin
            r_stage <= '0;
        end else if (i_en) begin
            r_stage <= '{valid: i_valid, data: i_data};
        end
    end

    assign o_valid = r_stage.valid;
    assign o_data  = r_stage.data;

endmodule

// File: rtl/pipeline_register.sv
// Delay line of STAGES register slots with a valid bit per slot, stall and flush.
// Q and q_valid come straight from the last slot's flops.
module pipeline_register
    import pipeline_register_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_PIPE_WIDTH,
    parameter int STAGES = 1
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] Q,
    output logic             q_valid
);

    generate
        if (STAGES < 1) begin : g_bad_stages
            $error("pipeline_register: STAGES must be >= 1");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("pipeline_register: WIDTH must be >= 1");
        end
    endgenerate

    // Index k is the input of slot k; index STAGES is the output of the last slot.
    logic             w_valid [0:STAGES];
    logic [WIDTH-1:0] w_data  [0:STAGES];

    assign w_valid[0] = in_valid;
    assign w_data[0]  = in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipeline_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .ck      (ck),
            .rst_n   (rst_n),
            .i_en    (en),
            .i_flush (flush),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1])
        );
    end

    assign Q       = w_data[STAGES];
    assign q_valid = w_valid[STAGES];

endmodule

// File: tb/tb_pipeline_register.sv
// Directed bench: a default 1x8 instance and a 3x16 instance share clock and reset.
// Inputs change 1ns after each rising edge; outputs are checked at that same point.
module tb_pipeline_register;

    logic        ck = 1'b0;
    logic        rst_n;

    logic        a_en, a_flush, a_v;
    logic [7:0]  a_in, a_q;
    logic        a_qv;

    logic        b_en, b_flush, b_v;
    logic [15:0] b_in, b_q;
    logic        b_qv;

    int n_total = 0;
    int n_bad   = 0;

    always #5 ck = ~ck;

    pipeline_register u_dut_a (
        .ck       (ck),
        .rst_n    (rst_n),
        .en       (a_en),
        .flush    (a_flush),
        .in_valid (a_v),
        .in       (a_in),
        .Q        (a_q),
        .q_valid  (a_qv)
    );

    pipeline_register #(
        .WIDTH  (16),
        .STAGES (3)
    ) u_dut_b (
        .ck       (ck),
        .rst_n    (rst_n),
        .en       (b_en),
        .flush    (b_flush),
        .in_valid (b_v),
        .in       (b_in),
        .Q        (b_q),
        .q_valid  (b_qv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] d, input logic v);
        chk({tag, ".q"}, {24'h0, a_q}, {24'h0, d});
        chk({tag, ".qv"}, {31'h0, a_qv}, {31'h0, v});
    endtask

    task automatic chk_b(input string tag, input logic [15:0] d, input logic v);
        chk({tag, ".q"}, {16'h0, b_q}, {16'h0, d});
        chk({tag, ".qv"}, {31'h0, b_qv}, {31'h0, v});
    endtask

    // Latency sweep vectors for the 3-stage instance: input, then expected Q after that edge.
    logic [15:0] lat_in   [0:4] = '{16'h1234, 16'hBEEF, 16'h0055, 16'h0000, 16'h0000};
    logic        lat_v    [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] lat_q    [0:4] = '{16'h0000, 16'h0000, 16'h1234, 16'hBEEF, 16'h0055};
    logic        lat_qv   [0:4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n   = 1'b0;
        a_en    = 1'b1; a_flush = 1'b0; a_v = 1'b1; a_in = 8'hA5;
        b_en    = 1'b1; b_flush = 1'b0; b_v = 1'b1; b_in = 16'hA5A5;

        // reset held two edges with live input
        step(); chk_a("rst0", 8'h00, 1'b0); chk_b("rst0_b", 16'h0, 1'b0);
        step(); chk_a("rst1", 8'h00, 1'b0);
        rst_n = 1'b1;
        b_en  = 1'b0;
        step(); chk_a("rst_rel", 8'hA5, 1'b1); chk_b("b_hold", 16'h0, 1'b0);

        // counting stream
        for (int i = 0; i < 6; i++) begin
            a_in = 8'(i);
            step();
            chk_a($sformatf("cnt%0d", i), 8'(i), 1'b1);
        end

        // wrap boundary
        a_in = 8'hFF; step(); chk_a("wrap_ff", 8'hFF, 1'b1);
        a_in = 8'h00; step(); chk_a("wrap_00", 8'h00, 1'b1);

        // stall: hold 11 across two en=0 edges
        a_in = 8'd10; step(); chk_a("st10", 8'd10, 1'b1);
        a_in = 8'd11; step(); chk_a("st11", 8'd11, 1'b1);
        a_en = 1'b0; a_in = 8'd12;
        step(); chk_a("stall0", 8'd11, 1'b1);
        step(); chk_a("stall1", 8'd11, 1'b1);
        a_en = 1'b1;
        step(); chk_a("st12", 8'd12, 1'b1);
        a_in = 8'd13; a_v = 1'b0;
        step(); chk_a("st13", 8'd13, 1'b0);

        // latency sweep on the 3-stage instance
        b_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_in = lat_in[i];
            b_v  = lat_v[i];
            step();
            chk_b($sformatf("lat%0d", i), lat_q[i], lat_qv[i]);
        end

        // flush with 20,21 in flight; 22 presented on the flush edge
        b_v = 1'b1;
        b_in = 16'd20; step(); chk_b("fl20", 16'h0, 1'b0);
        b_in = 16'd21; step(); chk_b("fl21", 16'h0, 1'b0);
        b_in = 16'd22; b_flush = 1'b1; step(); chk_b("flush", 16'h0, 1'b0);
        b_flush = 1'b0; b_v = 1'b0; b_in = 16'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_b($sformatf("post_fl%0d", i), 16'h0, 1'b0);
        end

        // flush must also win while stalled
        b_v = 1'b1; b_in = 16'h00AA;
        step(); step(); step(); chk_b("pre_fl2", 16'h00AA, 1'b1);
        b_en = 1'b0; b_flush = 1'b1;
        step(); chk_b("flush_stall", 16'h0, 1'b0);
        b_flush = 1'b0; b_en = 1'b1;

        // mid-stream reset drops in-flight data; first capture needs en=1
        a_v = 1'b1; a_in = 8'h3C;
        step(); chk_a("pre_rst", 8'h3C, 1'b1);
        rst_n = 1'b0; a_in = 8'h77;
        step(); chk_a("mid_rst", 8'h00, 1'b0); chk_b("mid_rst_b", 16'h0, 1'b0);
        rst_n = 1'b1; a_en = 1'b0;
        step(); chk_a("rel_hold", 8'h00, 1'b0);
        a_en = 1'b1;
        step(); chk_a("rel_cap", 8'h77, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
